spi_shift_reg: RTL and testbench
================================

SPI_SHIFT_REG -- requirements
Module: spi_shift_reg

Interface
REQ-001 Parameter SPI_MAX_CHAR, default 32, maximum character length in bits.
REQ-002 Parameter SPI_CHAR_LEN_BITS, default 5, width of len; equals log2(SPI_MAX_CHAR).
REQ-003 wb_clk_in  input  1  clock; all state changes on rising edge.
REQ-004 wb_rst  input  1  reset, asynchronous, active-high.
REQ-005 go  input  1  start-transfer request.
REQ-006 len  input  SPI_CHAR_LEN_BITS  character length; 0 means SPI_MAX_CHAR.
REQ-007 lsb  input  1  1 = LSB first, 0 = MSB first.
REQ-008 tx_negedge  input  1  1 = advance s_out on neg_edge, 0 = on pos_edge.
REQ-009 rx_negedge  input  1  1 = sample s_in on neg_edge, 0 = on pos_edge.
REQ-010 pos_edge  input  1  one-cycle pulse before sclk rising, from the clock generator.
REQ-011 neg_edge  input  1  one-cycle pulse before sclk falling, from the clock generator.
REQ-012 load  input  1  write p_in into the transmit word.
REQ-013 p_in  input  SPI_MAX_CHAR  parallel transmit data.
REQ-014 s_in  input  1  serial receive data (MISO).
REQ-015 tip  output  1  transfer in progress; drives the clock generator.
REQ-016 last_clk  output  1  final bit period; drives the clock generator.
REQ-017 s_out  output  1  serial transmit data (MOSI).
REQ-018 p_out  output  SPI_MAX_CHAR  received word.
REQ-019 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-020 Effective length L = (len==0) ? SPI_MAX_CHAR : len; all index arithmetic SHALL use SPI_CHAR_LEN_BITS+1 bits.
REQ-021 States SHALL be IDLE (tip=0) and XFER (tip=1).
REQ-022 IDLE->XFER: go=1 in IDLE sets tip=1 next cycle and clears tx_cnt and rx_cnt to 0.
REQ-023 go while tip=1 SHALL be ignored.
REQ-024 load while tip=0 SHALL write p_in into tx_data at the next edge; load while tip=1 SHALL be ignored.
REQ-025 load and go in the same IDLE cycle: the transfer SHALL send the newly loaded word.
REQ-026 Bit index function: idx(k) = lsb ? k : L-1-k.
REQ-027 s_out SHALL equal tx_data[idx(tx_cnt)] while tip=1 and 0 while tip=0, so bit 0 of the sequence is driven before the first clock edge.
REQ-028 Tx edge (neg_edge if tx_negedge, else pos_edge) with tip=1 SHALL increment tx_cnt, saturating at L-1.
REQ-029 Rx edge (neg_edge if rx_negedge, else pos_edge) with tip=1 SHALL write s_in into rx_data[idx(rx_cnt)] and increment rx_cnt.
REQ-030 Tx and rx edges in the same cycle SHALL both take effect.
REQ-031 last_clk SHALL be 1 iff tip=1 and rx_cnt==L-1.
REQ-032 XFER->IDLE: the rx edge that makes rx_cnt reach L SHALL clear tip and pulse done for exactly one cycle on the next cycle.
REQ-033 p_out SHALL equal rx_data continuously; rx_data bits at or above L SHALL be 0.
REQ-034 Changes to len, lsb, tx_negedge or rx_negedge during tip=1 are unsupported; the design SHALL latch L and lsb at go.

Reset
REQ-035 wb_rst=1 SHALL immediately force tip=0, done=0, last_clk=0, s_out=0, tx_data=0, rx_data=0, and counters=0, including mid-transfer; the block leaves reset in IDLE.

Structure
REQ-036 SPI_MAX_CHAR, SPI_CHAR_LEN_BITS and the IDLE/XFER encodings SHALL reside in the shared spi_defines package used with the clock generator.
REQ-037 Single module, no sub-module; the clock generator is instantiated alongside the block by the parent, not inside it.

Verification
REQ-038 p_in=0xA5, len=8, lsb=0, tx_negedge=1, rx_negedge=0, s_in looped to s_out, go -> s_out sequence 1,0,1,0,0,1,0,1; p_out=0x000000A5; done pulses once; tip=0 afterwards.
REQ-039 Same stimulus with lsb=1 -> s_out sequence 1,0,1,0,0,1,0,1 reversed (bit0 first); p_out=0x000000A5.
REQ-040 len=0, p_in=0xDEADBEEF, loopback -> 32 rx edges, p_out=0xDEADBEEF; last_clk high only during the 32nd bit.
REQ-041 go asserted again and load=1 with p_in=0x12 mid-transfer -> both ignored; tx_data unchanged; exactly one done pulse.
REQ-042 wb_rst asserted after 3 bits of an 8-bit transfer -> tip, s_out and p_out are 0 immediately; a new go runs a complete 8-bit transfer.
REQ-043 tx_negedge=rx_negedge=0 with pos_edge and neg_edge both high in one cycle -> a single tx advance and a single rx sample occur in that cycle.

Source files
------------

// File: rtl/spi_defines.sv
// Shared SPI master constants and state encodings, used by the shift register and the clock generator.
// No logic; no latency; no backpressure.
package spi_defines;

    localparam int SPI_MAX_CHAR      = 32;
    localparam int SPI_CHAR_LEN_BITS = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// SPI master shift register: serialises one character onto s_out and assembles p_out from s_in.
// Latency: one bit per tx/rx edge pulse; done one cycle after the final rx edge.
// Backpressure: none; the external clock generator paces all bit movement through pos_edge/neg_edge.
module spi_shift_reg #(
    parameter int SPI_MAX_CHAR      = spi_defines::SPI_MAX_CHAR,
    parameter int SPI_CHAR_LEN_BITS = spi_defines::SPI_CHAR_LEN_BITS
) (
    input  logic                         wb_clk_in,
    input  logic                         wb_rst,
    input  logic                         go,
    input  logic [SPI_CHAR_LEN_BITS-1:0] len,
    input  logic                         lsb,
    input  logic                         tx_negedge,
    input  logic                         rx_negedge,
    input  logic                         pos_edge,
    input  logic                         neg_edge,
    input  logic                         load,
    input  logic [SPI_MAX_CHAR-1:0]      p_in,
    input  logic                         s_in,
    output logic                         tip,
    output logic                         last_clk,
    output logic                         s_out,
    output logic [SPI_MAX_CHAR-1:0]      p_out,
    output logic                         done
);
    import spi_defines::*;

    // One extra bit so a full-width length (len==0) is representable.
    localparam int IW = SPI_CHAR_LEN_BITS + 1;
    typedef logic [IW-1:0] cnt_t;

    spi_state_e              state_q;
    logic                    done_q;
    logic                    lsb_q;
    cnt_t                    len_q;
    cnt_t                    tx_cnt_q, tx_cnt_d;
    cnt_t                    rx_cnt_q, rx_cnt_d;
    logic [SPI_MAX_CHAR-1:0] tx_data_q, tx_data_d;
    logic [SPI_MAX_CHAR-1:0] rx_data_q, rx_data_d;

    cnt_t eff_len;
    cnt_t last_idx;
    cnt_t tx_idx;
    cnt_t rx_idx;
    logic tip_w;
    logic tx_edge;
    logic rx_edge;

    function automatic cnt_t bit_idx(input cnt_t k, input cnt_t l, input logic lsb_first);
        return lsb_first ? k : cnt_t'(l - k - cnt_t'(1));
    endfunction

    always_comb begin
        tip_w    = (state_q == ST_XFER);
        eff_len  = (len == '0) ? cnt_t'(SPI_MAX_CHAR) : cnt_t'(len);
        last_idx = len_q - cnt_t'(1);
        tx_edge  = tx_negedge ? neg_edge : pos_edge;
        rx_edge  = rx_negedge ? neg_edge : pos_edge;
        tx_idx   = bit_idx(tx_cnt_q, len_q, lsb_q);
        rx_idx   = bit_idx(rx_cnt_q, len_q, lsb_q);
    end

    always_comb begin
        tx_data_d = tx_data_q;
        rx_data_d = rx_data_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        if (!tip_w) begin
            if (load) begin
                tx_data_d = p_in;
            end
            // Clearing rx_data here keeps bits above a shorter length at zero.
            if (go) begin
                tx_cnt_d  = '0;
                rx_cnt_d  = '0;
                rx_data_d = '0;
            end
        end else begin
            if (tx_edge && (tx_cnt_q != last_idx)) begin
                tx_cnt_d = tx_cnt_q + cnt_t'(1);
            end
            if (rx_edge) begin
                rx_data_d[rx_idx[SPI_CHAR_LEN_BITS-1:0]] = s_in;
                rx_cnt_d = rx_cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            len_q   <= '0;
            lsb_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_XFER;
                        len_q   <= eff_len;
                        lsb_q   <= lsb;
                    end
                end
                ST_XFER: begin
                    if (rx_edge && (rx_cnt_q == last_idx)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            tx_data_q <= '0;
            rx_data_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
        end else begin
            tx_data_q <= tx_data_d;
            rx_data_q <= rx_data_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    assign tip      = tip_w;
    assign s_out    = tip_w & tx_data_q[tx_idx[SPI_CHAR_LEN_BITS-1:0]];
    assign last_clk = tip_w && (rx_cnt_q == last_idx);
    assign p_out    = rx_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_shift_reg.sv
// Scoreboard bench for spi_shift_reg: driver emulates the clock generator, monitor checks each rx bit and each done.
module tb_spi_shift_reg;
    localparam int MC = 32;

    logic        wb_clk_in = 1'b0;
    logic        wb_rst    = 1'b1;
    logic        go = 1'b0, lsb = 1'b0, tx_negedge = 1'b0, rx_negedge = 1'b0;
    logic        pos_edge = 1'b0, neg_edge = 1'b0, load = 1'b0;
    logic [4:0]  len = '0;
    logic [31:0] p_in = '0;
    logic        s_in_drv = 1'b0;
    logic        loop_mode = 1'b1;
    logic        s_in;
    logic        tip, last_clk, s_out, done;
    logic [31:0] p_out;

    typedef struct {
        logic sbit;
        logic last;
    } bit_exp_t;

    bit_exp_t    exp_bits[$];
    logic [31:0] exp_words[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b1;

    assign s_in = loop_mode ? s_out : s_in_drv;

    always #5 wb_clk_in = ~wb_clk_in;

    spi_shift_reg #(.SPI_MAX_CHAR(32), .SPI_CHAR_LEN_BITS(5)) dut (
        .wb_clk_in (wb_clk_in),
        .wb_rst    (wb_rst),
        .go        (go),
        .len       (len),
        .lsb       (lsb),
        .tx_negedge(tx_negedge),
        .rx_negedge(rx_negedge),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .load      (load),
        .p_in      (p_in),
        .s_in      (s_in),
        .tip       (tip),
        .last_clk  (last_clk),
        .s_out     (s_out),
        .p_out     (p_out),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge wb_clk_in);
        #1;
    endtask

    // Monitor: pops the expected bit on every rx edge while busy and the expected word on every done.
    initial begin
        bit_exp_t e;
        logic [31:0] w;
        forever begin
            @(negedge wb_clk_in);
            if (mon_en && tip && (rx_negedge ? neg_edge : pos_edge)) begin
                if (exp_bits.size() == 0) fail_now("unexpected_rx_edge");
                else begin
                    e = exp_bits.pop_front();
                    chk("s_out_bit", {31'd0, s_out}, {31'd0, e.sbit});
                    chk("last_clk", {31'd0, last_clk}, {31'd0, e.last});
                end
            end
            if (done) begin
                done_cnt++;
                if (mon_en) begin
                    if (exp_words.size() == 0) fail_now("unexpected_done");
                    else begin
                        w = exp_words.pop_front();
                        chk("p_out_at_done", p_out, w);
                        chk("tip_at_done", {31'd0, tip}, 32'd0);
                    end
                end
            end
        end
    end

    // Reference: bit k of the character is word[lsb ? k : L-1-k]; the k-th received bit lands at the same index.
    task automatic run_xfer(input logic [31:0] w, input logic [4:0] ln, input logic lb,
                            input logic txn, input logic rxn, input bit loop, input bit both, input bit poke);
        int          L;
        int          idx;
        int          d0;
        int          g;
        logic [31:0] rb;
        logic [31:0] expw;
        bit_exp_t    e;
        L    = (ln == 5'd0) ? MC : int'(ln);
        rb   = $urandom;
        expw = '0;
        for (int k = 0; k < L; k++) begin
            idx = lb ? k : L - 1 - k;
            if (loop) rb[k] = w[idx];
            expw[idx] = rb[k];
            e.sbit = w[idx];
            e.last = (k == L - 1);
            exp_bits.push_back(e);
        end
        exp_words.push_back(expw);
        loop_mode = loop;
        load = 1'b1; p_in = w; go = 1'b1;
        len = ln; lsb = lb; tx_negedge = txn; rx_negedge = rxn;
        tick();
        load = 1'b0; go = 1'b0; p_in = $urandom;
        d0 = done_cnt;
        for (int k = 0; k < L; k++) begin
            g = $urandom_range(0, 2);
            repeat (g) tick();
            if (poke && k == L / 2) begin
                go = 1'b1; load = 1'b1; p_in = 32'h12;
                tick();
                go = 1'b0; load = 1'b0;
            end
            s_in_drv = rb[k];
            if (both) begin
                pos_edge = 1'b1; neg_edge = 1'b1;
            end else if (rxn) neg_edge = 1'b1;
            else pos_edge = 1'b1;
            tick();
            pos_edge = 1'b0; neg_edge = 1'b0;
            if (txn != rxn) begin
                if (txn) neg_edge = 1'b1;
                else pos_edge = 1'b1;
                tick();
                pos_edge = 1'b0; neg_edge = 1'b0;
            end
        end
        for (int t = 0; t < 8 && tip; t++) tick();
        chk("tip_after_xfer", {31'd0, tip}, 32'd0);
        tick(); tick();
        chk("done_pulses", done_cnt - d0, 32'd1);
        chk("s_out_idle", {31'd0, s_out}, 32'd0);
        chk("pending_bits", exp_bits.size(), 32'd0);
        chk("pending_words", exp_words.size(), 32'd0);
        exp_bits.delete();
        exp_words.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rl;
        logic       rtx, rrx;
        #12;
        chk("rst_tip", {31'd0, tip}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_last_clk", {31'd0, last_clk}, 32'd0);
        chk("rst_s_out", {31'd0, s_out}, 32'd0);
        chk("rst_p_out", p_out, 32'd0);
        wb_rst = 1'b0;
        tick();

        run_xfer(32'hA5, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_xfer(32'hA5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_xfer(32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_xfer(32'h5C, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Abort an 8-bit transfer after three bits with an asynchronous reset.
        mon_en = 1'b0;
        loop_mode = 1'b1;
        load = 1'b1; p_in = 32'hA5; go = 1'b1;
        len = 5'd8; lsb = 1'b0; tx_negedge = 1'b1; rx_negedge = 1'b0;
        tick();
        load = 1'b0; go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pos_edge = 1'b1; tick(); pos_edge = 1'b0;
            neg_edge = 1'b1; tick(); neg_edge = 1'b0;
        end
        chk("pre_rst_p_out", p_out, 32'hA0);
        chk("pre_rst_tip", {31'd0, tip}, 32'd1);
        #2 wb_rst = 1'b1;
        #1;
        chk("mid_rst_tip", {31'd0, tip}, 32'd0);
        chk("mid_rst_s_out", {31'd0, s_out}, 32'd0);
        chk("mid_rst_p_out", p_out, 32'd0);
        chk("mid_rst_last_clk", {31'd0, last_clk}, 32'd0);
        tick();
        wb_rst = 1'b0;
        tick();
        mon_en = 1'b1;
        run_xfer(32'h3C, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        run_xfer(32'h96, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rl  = 5'($urandom_range(0, 31));
            rtx = 1'($urandom_range(0, 1));
            rrx = 1'($urandom_range(0, 1));
            run_xfer($urandom, rl, 1'($urandom_range(0, 1)), rtx, rrx,
                     bit'($urandom_range(0, 1)),
                     (!rtx && !rrx && ($urandom_range(0, 1) == 1)),
                     ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
